// File: rtl/main_mem_responder_pkg.sv
// Shared types and constants for the main-memory responder: FSM states,
// fill destination encodings and the latency-pipe entry layout.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ISSUE,
        DRAIN
    } resp_state_t;

    localparam logic DEST_I = 1'b0;
    localparam logic DEST_D = 1'b1;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WORD_W = 3;

    // One in-flight read: where it goes, which word of the block it is, and its data.
    typedef struct packed {
        logic              valid;
        logic              dest;
        logic [WORD_W-1:0] word;
        logic [DATA_W-1:0] data;
    } pipe_entry_t;

    // Word-array index of word 'word' inside the block holding byte address 'addr'.
    // The block number is kept intact, so reads never wrap outside the block.
    function automatic logic [14:0] block_word_index(input logic [15:0] addr,
                                                     input logic [WORD_W-1:0] word);
        return {addr[15:4], word};
    endfunction

endpackage

// File: rtl/main_mem_responder_lat_pipe.sv
// Fixed-latency read pipe: a LATENCY-deep shift register of pipe entries.
// Only the valid bits are reset; the payload simply follows them.
module mem_lat_pipe
    import mem_resp_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  pipe_entry_t issue_entry,
    output pipe_entry_t beat_entry
);

    logic              valid_q [LATENCY];
    logic              dest_q  [LATENCY];
    logic [WORD_W-1:0] word_q  [LATENCY];
    logic [DATA_W-1:0] data_q  [LATENCY];

    // Shift the valid bits; reset empties the pipe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            valid_q[0] <= issue_entry.valid;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Shift the payload alongside the valid bits; no reset needed.
    always_ff @(posedge clk) begin
        dest_q[0] <= issue_entry.dest;
        word_q[0] <= issue_entry.word;
        data_q[0] <= issue_entry.data;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            dest_q[i] <= dest_q[i-1];
            word_q[i] <= word_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    // The oldest stage is the beat presented this cycle.
    always_comb begin
        beat_entry.valid = valid_q[LATENCY-1];
        beat_entry.dest  = dest_q[LATENCY-1];
        beat_entry.word  = word_q[LATENCY-1];
        beat_entry.data  = data_q[LATENCY-1];
    end

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder for the I-cache and D-cache miss handlers.
// Arbitrates fills and write-throughs (d_wr > d_req > i_req), performs
// single-word writes, and streams 8-word blocks through a fixed-latency pipe.
module main_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned MEM_WORDS   = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wdata,
    output logic        fill_valid,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        fill_dest,
    output logic        i_done,
    output logic        d_done,
    output logic        d_wr_ack,
    output logic        busy
);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

    resp_state_t       state_q;
    resp_state_t       state_d;

    logic              grant;
    logic              grant_dest;
    logic [15:0]       grant_addr;

    logic [15:0]       addr_q;
    logic              dest_q;
    logic [WORD_W-1:0] cnt_q;

    logic [15:0]       mem [MEM_WORDS];

    pipe_entry_t       issue_entry;
    pipe_entry_t       beat_entry;
    logic              last_beat;

    // Byte-lane bit of the latched address has no meaning for a word memory.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = addr_q[0];

    // The final word of the block leaving the pipe ends a fill.
    assign last_beat = beat_entry.valid && (beat_entry.word == LAST_WORD);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, grant arbitration and status outputs.
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_dest = DEST_I;
        grant_addr = i_addr;
        d_wr_ack   = 1'b0;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (d_wr) begin
                    state_d    = WRITE;
                    grant      = 1'b1;
                    grant_addr = d_addr;
                end else if (d_req) begin
                    state_d    = ISSUE;
                    grant      = 1'b1;
                    grant_dest = DEST_D;
                    grant_addr = d_addr;
                end else if (i_req) begin
                    state_d    = ISSUE;
                    grant      = 1'b1;
                end
            end
            WRITE: begin
                d_wr_ack = 1'b1;
                state_d  = IDLE;
            end
            ISSUE: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch address and destination at grant; step the issue counter during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            dest_q <= DEST_I;
            cnt_q  <= '0;
        end else if (grant) begin
            addr_q <= grant_addr;
            dest_q <= grant_dest;
            cnt_q  <= '0;
        end else if (state_q == ISSUE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Write-through commit: data is taken while in WRITE, address from the grant.
    always_ff @(posedge clk) begin
        if (state_q == WRITE) begin
            mem[addr_q[15:1]] <= d_wdata;
        end
    end

    // Read word cnt_q of the latched block; the pipe's first stage registers it.
    always_comb begin
        issue_entry.valid = (state_q == ISSUE);
        issue_entry.dest  = dest_q;
        issue_entry.word  = cnt_q;
        issue_entry.data  = mem[block_word_index(addr_q, cnt_q)];
    end

    mem_lat_pipe #(
        .LATENCY(LATENCY)
    ) u_lat_pipe (
        .clk        (clk),
        .rst        (rst),
        .issue_entry(issue_entry),
        .beat_entry (beat_entry)
    );

    // Beat outputs are forced to zero whenever no beat is valid.
    always_comb begin
        fill_valid = beat_entry.valid;
        fill_data  = beat_entry.valid ? beat_entry.data : '0;
        fill_word  = beat_entry.valid ? beat_entry.word : '0;
        fill_dest  = beat_entry.valid && beat_entry.dest;
        i_done     = last_beat && (beat_entry.dest == DEST_I);
        d_done     = last_beat && (beat_entry.dest == DEST_D);
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: scoreboard of expected beats
// (cycle, destination, word, data) built from a reference memory model.
module tb_main_mem_responder;
    import mem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        fill_valid, fill_dest, i_done, d_done, d_wr_ack, busy;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;

    logic        i_req_b, d_req_b, d_wr_b;
    logic [15:0] i_addr_b, d_addr_b, d_wdata_b;
    logic        fill_valid_b, fill_dest_b, i_done_b, d_done_b, d_wr_ack_b, busy_b;
    logic [15:0] fill_data_b;
    logic [2:0]  fill_word_b;

    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;

    typedef struct {
        int          cyc;
        logic        dest;
        logic [2:0]  word;
        logic [15:0] data;
    } beat_t;

    beat_t       sb[$];
    logic [15:0] model [int];

    main_mem_responder #(.LATENCY(4), .BLOCK_WORDS(8), .MEM_WORDS(32768)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
        .d_wr(d_wr), .d_wdata(d_wdata),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_word(fill_word),
        .fill_dest(fill_dest), .i_done(i_done), .d_done(d_done),
        .d_wr_ack(d_wr_ack), .busy(busy)
    );

    main_mem_responder #(.LATENCY(1), .BLOCK_WORDS(8), .MEM_WORDS(32768)) dut_b (
        .clk(clk), .rst(rst),
        .i_req(i_req_b), .i_addr(i_addr_b), .d_req(d_req_b), .d_addr(d_addr_b),
        .d_wr(d_wr_b), .d_wdata(d_wdata_b),
        .fill_valid(fill_valid_b), .fill_data(fill_data_b), .fill_word(fill_word_b),
        .fill_dest(fill_dest_b), .i_done(i_done_b), .d_done(d_done_b),
        .d_wr_ack(d_wr_ack_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Push the 8 expected beats of a fill granted in cycle t0.
    task automatic expect_block(input logic dest, input logic [15:0] addr,
                                input int t0, input int lat);
        beat_t e;
        logic [15:0] base;
        base = {addr[15:4], 4'h0};
        for (int k = 0; k < 8; k++) begin
            e.cyc  = t0 + 1 + k + lat;
            e.dest = dest;
            e.word = 3'(k);
            e.data = model[int'(base >> 1) + k];
            sb.push_back(e);
        end
    endtask

    task automatic test_reset_state();
        rst = 1'b1;
        i_req = 0; d_req = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        i_req_b = 0; d_req_b = 0; d_wr_b = 0; i_addr_b = '0; d_addr_b = '0; d_wdata_b = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({fill_valid, fill_data, fill_word, fill_dest, i_done, d_done, d_wr_ack, busy} !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h, expected 000000",
                     {fill_valid, fill_data, fill_word, fill_dest, i_done, d_done, d_wr_ack, busy});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [15:0] bases [5];
        logic [15:0] seeds [5];
        logic [15:0] a, v;
        bases = '{16'h0010, 16'h0020, 16'h0100, 16'h0200, 16'hFFF0};
        seeds = '{16'h00A0, 16'h2000, 16'h1000, 16'h5500, 16'hF000};
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 8; k++) begin
                a = bases[b] + 16'(2 * k);
                v = seeds[b] + 16'(k);
                @(negedge clk);
                d_wr = 1; d_addr = a; d_wdata = v;
                model[int'(a >> 1)] = v;
                @(negedge clk);
                vectors++;
                if (d_wr_ack !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL write_ack: addr=%h ack=%b busy=%b, expected ack=1 busy=1", a, d_wr_ack, busy);
                end
                d_wr = 0;
                @(negedge clk);
                vectors++;
                if (d_wr_ack !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL write_idle: addr=%h ack=%b busy=%b, expected ack=0 busy=0", a, d_wr_ack, busy);
                end
            end
        end
    endtask

    task automatic test_single_fill();
        beat_t e;
        int t0;
        @(negedge clk);
        i_req = 1; i_addr = 16'h0016;
        t0 = cyc;
        expect_block(DEST_I, 16'h0016, t0, 4);
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (fill_valid) begin
                vectors++;
                e = sb.pop_front();
                if (cyc !== e.cyc || fill_dest !== e.dest || fill_word !== e.word || fill_data !== e.data
                    || i_done !== (e.word == 3'd7 && e.dest == DEST_I) || d_done !== (e.word == 3'd7 && e.dest == DEST_D)) begin
                    errors++;
                    $display("FAIL single_fill beat: cyc=%0d dest=%0d word=%0d data=%h idone=%b ddone=%b, expected cyc=%0d dest=%0d word=%0d data=%h",
                             cyc, fill_dest, fill_word, fill_data, i_done, d_done, e.cyc, e.dest, e.word, e.data);
                end
            end
            if (i_done) i_req = 0;
            if (d_done) d_req = 0;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_fill timeout: %0d beats missing, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cyc !== t0 + 13) begin
            errors++;
            $display("FAIL single_fill busy_fall: busy=%b at T+%0d, expected busy=0 at T+13", busy, cyc - t0);
        end
    endtask

    task automatic test_reset_mid_fill();
        beat_t e;
        int t0;
        @(negedge clk);
        i_req = 1; i_addr = 16'h0010;
        t0 = cyc;
        expect_block(DEST_I, 16'h0010, t0, 4);
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (fill_valid) begin
                vectors++;
                e = sb.pop_front();
                if (cyc !== e.cyc || fill_word !== e.word || fill_data !== e.data || i_done !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_fill beat: cyc=%0d word=%0d data=%h idone=%b, expected cyc=%0d word=%0d data=%h",
                             cyc, fill_word, fill_data, i_done, e.cyc, e.word, e.data);
                end
                if (e.word == 3'd3) break;
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({fill_valid, fill_data, fill_word, fill_dest, i_done, d_done, d_wr_ack, busy} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid_fill outputs: %h, expected 000000",
                     {fill_valid, fill_data, fill_word, fill_dest, i_done, d_done, d_wr_ack, busy});
        end
        sb.delete();
        i_req = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++;
            if (fill_valid !== 1'b0 || i_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_fill quiet: valid=%b idone=%b busy=%b, expected 0 0 0", fill_valid, i_done, busy);
            end
        end
        @(negedge clk);
        i_req = 1; i_addr = 16'h0010;
        t0 = cyc;
        expect_block(DEST_I, 16'h0010, t0, 4);
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (fill_valid) begin
                vectors++;
                e = sb.pop_front();
                if (cyc !== e.cyc || fill_dest !== e.dest || fill_word !== e.word || fill_data !== e.data
                    || i_done !== (e.word == 3'd7)) begin
                    errors++;
                    $display("FAIL reset_refill beat: cyc=%0d dest=%0d word=%0d data=%h idone=%b, expected cyc=%0d dest=%0d word=%0d data=%h",
                             cyc, fill_dest, fill_word, fill_data, i_done, e.cyc, e.dest, e.word, e.data);
                end
            end
            if (i_done) i_req = 0;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_refill timeout: %0d beats missing, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_priority();
        beat_t e;
        int t0;
        @(negedge clk);
        d_wr = 1; d_addr = 16'h0102; d_wdata = 16'hBEEF;
        d_req = 1; i_req = 1; i_addr = 16'h0010;
        t0 = cyc;
        model[int'(16'h0102 >> 1)] = 16'hBEEF;
        @(negedge clk);
        vectors++;
        if (d_wr_ack !== 1'b1 || fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL priority ack: ack=%b valid=%b at T+%0d, expected ack=1 valid=0 at T+1", d_wr_ack, fill_valid, cyc - t0);
        end
        d_wr = 0; d_addr = 16'h0100;
        expect_block(DEST_D, 16'h0100, t0 + 2, 4);
        expect_block(DEST_I, 16'h0010, t0 + 15, 4);
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (fill_valid) begin
                vectors++;
                e = sb.pop_front();
                if (cyc !== e.cyc || fill_dest !== e.dest || fill_word !== e.word || fill_data !== e.data
                    || i_done !== (e.word == 3'd7 && e.dest == DEST_I) || d_done !== (e.word == 3'd7 && e.dest == DEST_D)) begin
                    errors++;
                    $display("FAIL priority beat: T+%0d dest=%0d word=%0d data=%h idone=%b ddone=%b, expected T+%0d dest=%0d word=%0d data=%h",
                             cyc - t0, fill_dest, fill_word, fill_data, i_done, d_done, e.cyc - t0, e.dest, e.word, e.data);
                end
            end
            if (i_done) i_req = 0;
            if (d_done) d_req = 0;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL priority timeout: %0d beats missing, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        beat_t e;
        int t0;
        @(negedge clk);
        i_req = 1; i_addr = 16'h0010;
        t0 = cyc;
        expect_block(DEST_I, 16'h0010, t0, 4);
        expect_block(DEST_I, 16'h0020, t0 + 13, 4);
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (fill_valid) begin
                vectors++;
                e = sb.pop_front();
                if (cyc !== e.cyc || fill_dest !== e.dest || fill_word !== e.word || fill_data !== e.data
                    || i_done !== (e.word == 3'd7)) begin
                    errors++;
                    $display("FAIL back_to_back beat: T+%0d dest=%0d word=%0d data=%h idone=%b, expected T+%0d dest=%0d word=%0d data=%h",
                             cyc - t0, fill_dest, fill_word, fill_data, i_done, e.cyc - t0, e.dest, e.word, e.data);
                end
            end
            if (i_done) i_req = 0;
            if (cyc == t0 + 13) begin
                i_req = 1; i_addr = 16'h0020;
            end
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back timeout: %0d beats missing, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_drop_req();
        beat_t e;
        int t0;
        @(negedge clk);
        d_req = 1; d_addr = 16'h0204;
        t0 = cyc;
        expect_block(DEST_D, 16'h0200, t0, 4);
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (fill_valid) begin
                vectors++;
                e = sb.pop_front();
                if (cyc !== e.cyc || fill_dest !== e.dest || fill_word !== e.word || fill_data !== e.data
                    || d_done !== (e.word == 3'd7)) begin
                    errors++;
                    $display("FAIL drop_req beat: T+%0d dest=%0d word=%0d data=%h ddone=%b, expected T+%0d dest=%0d word=%0d data=%h",
                             cyc - t0, fill_dest, fill_word, fill_data, d_done, e.cyc - t0, e.dest, e.word, e.data);
                end
                if (fill_word == 3'd1) begin
                    d_req = 0; d_addr = 16'h0010;
                end
            end
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drop_req timeout: %0d beats missing, expected 0", sb.size());
            sb.delete();
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || fill_valid !== 1'b0) begin
                errors++;
                $display("FAIL drop_req idle: busy=%b valid=%b, expected 0 0", busy, fill_valid);
            end
        end
    endtask

    task automatic test_top_of_mem();
        beat_t e;
        int t0;
        @(negedge clk);
        i_req = 1; i_addr = 16'hFFF8;
        t0 = cyc;
        expect_block(DEST_I, 16'hFFF8, t0, 4);
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (fill_valid) begin
                vectors++;
                e = sb.pop_front();
                if (cyc !== e.cyc || fill_word !== e.word || fill_data !== e.data || i_done !== (e.word == 3'd7)) begin
                    errors++;
                    $display("FAIL top_of_mem beat: T+%0d word=%0d data=%h idone=%b, expected T+%0d word=%0d data=%h",
                             cyc - t0, fill_word, fill_data, i_done, e.cyc - t0, e.word, e.data);
                end
            end
            if (i_done) i_req = 0;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL top_of_mem timeout: %0d beats missing, expected 0", sb.size());
            sb.delete();
        end
        // Same block through the LATENCY=1 instance.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d_wr_b = 1; d_addr_b = 16'hFFF0 + 16'(2 * k); d_wdata_b = model[int'(16'hFFF0 >> 1) + k];
            @(negedge clk);
            vectors++;
            if (d_wr_ack_b !== 1'b1) begin
                errors++;
                $display("FAIL lat1_write_ack: ack=%b, expected 1", d_wr_ack_b);
            end
            d_wr_b = 0;
        end
        @(negedge clk);
        i_req_b = 1; i_addr_b = 16'hFFF6;
        t0 = cyc;
        expect_block(DEST_I, 16'hFFF6, t0, 1);
        for (int c = 0; c < 30 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (fill_valid_b) begin
                vectors++;
                e = sb.pop_front();
                if (cyc !== e.cyc || fill_word_b !== e.word || fill_data_b !== e.data || i_done_b !== (e.word == 3'd7)) begin
                    errors++;
                    $display("FAIL lat1 beat: T+%0d word=%0d data=%h idone=%b, expected T+%0d word=%0d data=%h",
                             cyc - t0, fill_word_b, fill_data_b, i_done_b, e.cyc - t0, e.word, e.data);
                end
                if (i_done_b) begin
                    vectors++;
                    if (cyc - t0 !== 9) begin
                        errors++;
                        $display("FAIL lat1 grant_to_done: %0d cycles, expected 9", cyc - t0);
                    end
                end
            end
            if (i_done_b) i_req_b = 0;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL lat1 timeout: %0d beats missing, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        vectors++;
        if (busy_b !== 1'b0 || fill_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL lat1 idle: busy=%b valid=%b, expected 0 0", busy_b, fill_valid_b);
        end
    endtask

    initial begin
        test_reset_state();
        test_write();
        test_single_fill();
        test_reset_mid_fill();
        test_priority();
        test_back_to_back();
        test_drop_req();
        test_top_of_mem();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
